// File: rtl/decode_stage_pipe.sv
// RV32I instruction-decode stage: field/immediate/control decode, register file, load-use stall, ID/EX register.
// Optional write-first register-file bypass is enabled by defining IDU_RF_BYPASS_EN.
module decode_stage_pipe #(
  parameter int DataWidth  = 32,
  parameter int RegAddress = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DataWidth-1:0]  in_instr,
  input  logic [DataWidth-1:0]  in_pc,
  input  logic                  flush,
  input  logic                  wb_en,
  input  logic [RegAddress-1:0] wb_rd,
  input  logic [DataWidth-1:0]  wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DataWidth-1:0]  out_pc,
  output logic [RegAddress-1:0] out_rs1,
  output logic [RegAddress-1:0] out_rs2,
  output logic [RegAddress-1:0] out_rd,
  output logic [DataWidth-1:0]  out_rs1_data,
  output logic [DataWidth-1:0]  out_rs2_data,
  output logic [DataWidth-1:0]  out_imm,
  output logic [3:0]            out_alu_op,
  output logic                  out_load,
  output logic                  out_store,
  output logic                  out_branch,
  output logic                  out_jal,
  output logic                  out_jalr,
  output logic                  out_lui,
  output logic                  out_auipc,
  output logic                  out_reg_write,
  output logic                  out_illegal,
  output logic [2:0]            out_funct3
);
  localparam int NumRegs = 2 ** RegAddress;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  logic [31:0]           instr;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  f7b5;
  logic [RegAddress-1:0] rd, rs1, rs2;

  assign instr  = in_instr[31:0];
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b5   = instr[30];
  assign rd     = RegAddress'(instr[11:7]);
  assign rs1    = RegAddress'(instr[19:15]);
  assign rs2    = RegAddress'(instr[24:20]);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic       d_load, d_store, d_branch, d_jal, d_jalr, d_lui, d_auipc, d_illegal;
  logic       d_writes, d_reg_write, uses_rs1, uses_rs2;
  logic [3:0] d_alu_op;

  always_comb begin
    d_load = 1'b0; d_store = 1'b0; d_branch = 1'b0; d_jal = 1'b0;
    d_jalr = 1'b0; d_lui = 1'b0; d_auipc = 1'b0; d_illegal = 1'b0;
    d_writes = 1'b0; uses_rs1 = 1'b0; uses_rs2 = 1'b0;
    d_alu_op = 4'b0000;
    imm32    = 32'b0;
    case (opcode)
      OpR:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; d_writes = 1'b1; d_alu_op = {f7b5, funct3}; end
      OpImm:    begin
        uses_rs1 = 1'b1; d_writes = 1'b1; imm32 = imm_i;
        d_alu_op = {(funct3 == 3'b101) ? f7b5 : 1'b0, funct3};
      end
      OpLoad:   begin d_load = 1'b1; uses_rs1 = 1'b1; d_writes = 1'b1; imm32 = imm_i; end
      OpStore:  begin d_store = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm32 = imm_s; end
      OpBranch: begin d_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm32 = imm_b; end
      OpJal:    begin d_jal = 1'b1; d_writes = 1'b1; imm32 = imm_j; end
      OpJalr:   begin d_jalr = 1'b1; uses_rs1 = 1'b1; d_writes = 1'b1; imm32 = imm_i; end
      OpLui:    begin d_lui = 1'b1; d_writes = 1'b1; imm32 = imm_u; end
      OpAuipc:  begin d_auipc = 1'b1; d_writes = 1'b1; imm32 = imm_u; end
      default:  d_illegal = 1'b1;
    endcase
    d_reg_write = d_writes && (rd != '0);
  end

  logic [DataWidth-1:0] rf [NumRegs];
  logic [DataWidth-1:0] rs1_data, rs2_data;
  logic                 wb_live;

  assign wb_live = wb_en && (wb_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumRegs; i++) rf[i] <= '0;
    end else if (wb_live) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = (rs1 == '0) ? '0 : rf[rs1];
    rs2_data = (rs2 == '0) ? '0 : rf[rs2];
`ifdef IDU_RF_BYPASS_EN
    // Write-first: a same-cycle write-back is visible to the instruction being decoded.
    if (wb_live && (wb_rd == rs1)) rs1_data = wb_data;
    if (wb_live && (wb_rd == rs2)) rs2_data = wb_data;
`endif
  end

  // Handshake: a transfer happens on any edge where valid && ready; valid never waits on ready,
  // the producer holds its payload stable while valid && !ready, and flush forces in_ready high.
  logic hz, accept;
  assign hz = out_valid && out_load && (out_rd != '0) && in_valid &&
              ((uses_rs1 && (rs1 == out_rd)) || (uses_rs2 && (rs2 == out_rd)));
  assign in_ready = rst && (flush || (!hz && (!out_valid || out_ready)));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc <= '0; out_rs1 <= '0; out_rs2 <= '0; out_rd <= '0;
      out_rs1_data <= '0; out_rs2_data <= '0; out_imm <= '0; out_alu_op <= '0;
      out_load <= 1'b0; out_store <= 1'b0; out_branch <= 1'b0; out_jal <= 1'b0;
      out_jalr <= 1'b0; out_lui <= 1'b0; out_auipc <= 1'b0; out_reg_write <= 1'b0;
      out_illegal <= 1'b0; out_funct3 <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1       <= rs1;
      out_rs2       <= rs2;
      out_rd        <= rd;
      out_rs1_data  <= rs1_data;
      out_rs2_data  <= rs2_data;
      out_imm       <= DataWidth'($signed(imm32));
      out_alu_op    <= d_alu_op;
      out_load      <= d_load;
      out_store     <= d_store;
      out_branch    <= d_branch;
      out_jal       <= d_jal;
      out_jalr      <= d_jalr;
      out_lui       <= d_lui;
      out_auipc     <= d_auipc;
      out_reg_write <= d_reg_write;
      out_illegal   <= d_illegal;
      out_funct3    <= funct3;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid && wb_live) begin
      // Stalled operands track write-backs so execute never sees a stale value.
      if (wb_rd == out_rs1) out_rs1_data <= wb_data;
      if (wb_rd == out_rs2) out_rs2_data <= wb_data;
    end
  end
endmodule
